// File: rtl/add_serial.sv
`default_nettype none
// ============================================================================
//  Module      : add_serial
//  Description : Digit-serial adder/subtractor, DIGIT bits per clock, LSB
//                digit first, valid/ready on both sides, registered carry.
//  Revision    : 1.0 - initial release
// ============================================================================
module add_serial #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);
    localparam int              c_N    = WIDTH / DIGIT;
    localparam int              c_CW   = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_N - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    generate
        if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_digit
            $error("add_serial: DIGIT must be in 1..WIDTH and divide WIDTH");
        end
    endgenerate

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [c_CW-1:0]  r_count;
    logic             r_carry;
    logic             r_c_out;
    logic             r_ovf;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [DIGIT:0]   w_full;
    logic [DIGIT-1:0] w_dig;
    logic             w_carry;
    logic             w_msb_cin;
    logic [31:0]      w_shift;
    logic [WIDTH-1:0] w_mask;
    logic [WIDTH-1:0] w_place;

    // Operands shift right each RUN cycle, so the active digit is always at the bottom.
    assign w_full    = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};
    assign w_dig     = w_full[DIGIT-1:0];
    assign w_carry   = w_full[DIGIT];
    // Carry into the digit MSB recovered from the MSB sum bit: s = a ^ b ^ cin.
    assign w_msb_cin = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_dig[DIGIT-1];
    assign w_shift   = 32'(r_count) * DIGIT;
    assign w_mask    = WIDTH'({DIGIT{1'b1}}) << w_shift;
    assign w_place   = WIDTH'(w_dig) << w_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_count     <= '0;
            r_carry     <= 1'b0;
            r_c_out     <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_a        <= a;
                        r_b        <= sub ? ~b : b;
                        r_carry    <= sub | c_in;
                        r_count    <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_sum   <= (r_sum & ~w_mask) | w_place;
                    r_carry <= w_carry;
                    r_a     <= r_a >> DIGIT;
                    r_b     <= r_b >> DIGIT;
                    r_count <= r_count + c_CW'(1);
                    if (r_count == c_LAST) begin
                        r_c_out     <= w_carry;
                        r_ovf       <= w_carry ^ w_msb_cin;
                        r_out_valid <= 1'b1;
                        r_state     <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= c_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= c_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign c_out     = r_c_out;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_add_serial.sv
`default_nettype none
// ============================================================================
//  Module      : tb_add_serial
//  Description : Self-checking bench for add_serial (16/4 and 1/1 instances).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_add_serial;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, out_ready, c_in, sub;
    logic [15:0] a, b;
    logic        in_ready, out_valid, c_out, ovf;
    logic [15:0] sum;

    logic        v1_in_valid, v1_out_ready, v1_c_in, v1_sub;
    logic [0:0]  v1_a, v1_b, v1_sum;
    logic        v1_in_ready, v1_out_valid, v1_c_out, v1_ovf;

    add_serial #(.WIDTH(16), .DIGIT(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .c_out(c_out), .ovf(ovf)
    );

    add_serial #(.WIDTH(1), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(v1_in_valid), .in_ready(v1_in_ready),
        .a(v1_a), .b(v1_b), .c_in(v1_c_in), .sub(v1_sub), .out_valid(v1_out_valid),
        .out_ready(v1_out_ready), .sum(v1_sum), .c_out(v1_c_out), .ovf(v1_ovf)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sb;
        logic [15:0] es;
        logic        ec;
        logic        eo;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Reference: integer arithmetic; ovf = true signed result out of 16-bit range.
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mci, input logic msb);
        logic [15:0] bb;
        int          ci, u, s;
        logic        o;
        bb = msb ? ~mb : mb;
        ci = (msb || mci) ? 1 : 0;
        u  = int'(ma) + int'(bb) + ci;
        s  = int'($signed(ma)) + int'($signed(bb)) + ci;
        o  = (s > 32767) || (s < -32768);
        return {o, u[16], u[15:0]};
    endfunction

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tci,
                          input logic tsb, input int hold, input string name,
                          output logic [15:0] rs, output logic rc, output logic ro);
        int w;
        int lat;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check({name, ".in_ready"}, 32'(in_ready), 32'd1);
        a = ta; b = tb; c_in = tci; sub = tsb; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 40) begin
            in_valid = 1'($urandom);
            a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
            out_ready = 1'($urandom);
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (!out_valid) check({name, ".run_in_ready"}, 32'(in_ready), 32'd0);
        end
        check({name, ".latency"}, 32'(lat), 32'd4);
        rs = sum; rc = c_out; ro = ovf;
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom);
            @(posedge clk);
            @(negedge clk);
            check({name, ".hold_valid"}, 32'(out_valid), 32'd1);
            check({name, ".hold_ready"}, 32'(in_ready), 32'd0);
            check({name, ".hold_res"}, {14'd0, ovf, c_out, sum}, {14'd0, ro, rc, rs});
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({name, ".taken_valid"}, 32'(out_valid), 32'd0);
        check({name, ".taken_ready"}, 32'(in_ready), 32'd1);
    endtask

    task automatic run_op1(input logic ta, input logic tb, input logic tci, input string name);
        int          lat;
        int          s;
        logic [1:0]  u;
        u = 2'(ta) + 2'(tb) + 2'(tci);
        s = -int'(ta) - int'(tb) + int'(tci);
        v1_a = ta; v1_b = tb; v1_c_in = tci; v1_sub = 1'b0; v1_in_valid = 1'b1;
        @(posedge clk);
        lat = 0;
        @(negedge clk);
        v1_in_valid = 1'b0;
        while (!v1_out_valid && lat < 10) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({name, ".latency"}, 32'(lat), 32'd1);
        check({name, ".sum"}, {30'd0, v1_c_out, v1_sum}, {30'd0, u});
        check({name, ".ovf"}, 32'(v1_ovf), 32'((s < -1) || (s > 0)));
        v1_out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v1_out_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] rs;
        logic        rc, ro;
        logic [17:0] m;
        logic [15:0] ra, rb;
        logic        rci, rsb;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[3] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};

        rst = 1'b1;
        in_valid = 0; out_ready = 0; c_in = 0; sub = 0; a = '0; b = '0;
        v1_in_valid = 0; v1_out_ready = 0; v1_c_in = 0; v1_sub = 0; v1_a = '0; v1_b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset.in_ready", 32'(in_ready), 32'd1);
        check("reset.out_valid", 32'(out_valid), 32'd0);
        check("reset.res", {14'd0, ovf, c_out, sum}, 32'd0);
        check("reset1.in_ready", 32'(v1_in_ready), 32'd1);

        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sb, (i == 0) ? 3 : 1,
                   $sformatf("vec%0d", i), rs, rc, ro);
            check($sformatf("vec%0d.res", i), {14'd0, ro, rc, rs},
                  {14'd0, vecs[i].eo, vecs[i].ec, vecs[i].es});
        end

        // Reset on the second RUN edge discards the partial result.
        a = 16'h1234; b = 16'h1111; c_in = 0; sub = 0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("midrst.in_ready", 32'(in_ready), 32'd1);
        check("midrst.out_valid", 32'(out_valid), 32'd0);
        check("midrst.res", {14'd0, ovf, c_out, sum}, 32'd0);
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 0, "postrst", rs, rc, ro);
        check("postrst.res", {14'd0, ro, rc, rs}, {14'd0, 1'b0, 1'b0, 16'h0100});

        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rci = 1'($urandom); rsb = 1'($urandom);
            if (i % 5 == 0) ra = 16'h8000 ^ 16'($urandom_range(0, 3));
            m = model(ra, rb, rci, rsb);
            run_op(ra, rb, rci, rsb, int'($urandom_range(0, 2)), $sformatf("rnd%0d", i), rs, rc, ro);
            check($sformatf("rnd%0d.res", i), {14'd0, ro, rc, rs}, {14'd0, m});
        end

        for (int i = 0; i < 8; i++) begin
            run_op1(1'(i >> 2), 1'(i >> 1), 1'(i), $sformatf("w1_%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
